// File: rtl/fetch_pkg.sv
// Shared types, constants and helpers for the LEGv8 instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP   = 32'hD503201F;
    localparam int unsigned OFF_W = 26;

    // Word offset to byte displacement: sign-extend to 64 bits, then x4.
    function automatic logic [63:0] sext_shift2(input logic [OFF_W-1:0] off);
        logic [63:0] v;
        v = {{(64-OFF_W){off[OFF_W-1]}}, off};
        return v << 2;
    endfunction

endpackage

// File: rtl/branch_target_calc.sv
// Branch target: redir_pc plus the selected sign-extended word offset.
module branch_target_calc
    import fetch_pkg::*;
#(
    parameter int PC_W = 64
) (
    input  logic            i_uncond,
    input  logic [PC_W-1:0] i_pc,
    input  logic [18:0]     i_cond19,
    input  logic [25:0]     i_br26,
    output logic [PC_W-1:0] o_target
);

    logic [OFF_W-1:0] w_off;
    logic [63:0]      w_disp;

    assign w_off    = i_uncond ? i_br26
                               : {{(OFF_W-19){i_cond19[18]}}, i_cond19};
    assign w_disp   = sext_shift2(w_off);
    assign o_target = i_pc + w_disp[PC_W-1:0];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, one-outstanding imem requests, stall hold
// buffer, branch redirect/flush and the IF/ID output registers.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int              PC_W     = 64,
    parameter int              INSTR_W  = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               redir_en,
    input  logic               redir_uncond,
    input  logic [PC_W-1:0]    redir_pc,
    input  logic [18:0]        CondAddr19,
    input  logic [25:0]        BrAddr26,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_valid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_valid,
    output logic [PC_W-1:0]    if_pc,
    output logic [INSTR_W-1:0] if_instr
);

    localparam logic [INSTR_W-1:0] W_NOP = INSTR_W'(NOP);

    fetch_state_t       r_state;
    logic [PC_W-1:0]    r_pc;
    logic [PC_W-1:0]    r_hold_pc;
    logic [INSTR_W-1:0] r_hold_instr;
    logic               r_if_valid;
    logic [PC_W-1:0]    r_if_pc;
    logic [INSTR_W-1:0] r_if_instr;

    fetch_state_t       w_state_nxt;
    logic [PC_W-1:0]    w_pc_nxt;
    logic [PC_W-1:0]    w_target;
    logic               w_hold_ld;
    logic               w_emit_mem;
    logic               w_emit_hold;

    branch_target_calc #(.PC_W(PC_W)) u_btc (
        .i_uncond (redir_uncond),
        .i_pc     (redir_pc),
        .i_cond19 (CondAddr19),
        .i_br26   (BrAddr26),
        .o_target (w_target)
    );

    assign imem_req  = (r_state == REQ);
    assign imem_addr = r_pc;
    assign if_valid  = r_if_valid;
    assign if_pc     = r_if_pc;
    assign if_instr  = r_if_instr;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_hold_ld   = 1'b0;
        w_emit_mem  = 1'b0;
        w_emit_hold = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_state_nxt = REQ;
                if (redir_en) w_pc_nxt = w_target;
            end
            REQ: begin
                // A response arriving alongside a redirect is wrong-path.
                if (redir_en) begin
                    w_pc_nxt = w_target;
                    if (!imem_valid) w_state_nxt = DRAIN;
                end else if (imem_valid) begin
                    w_pc_nxt = r_pc + PC_W'(4);
                    if (stall) begin
                        w_hold_ld   = 1'b1;
                        w_state_nxt = HOLD;
                    end else begin
                        w_emit_mem = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (redir_en) begin
                    w_pc_nxt    = w_target;
                    w_state_nxt = REQ;
                end else if (!stall) begin
                    w_emit_hold = 1'b1;
                    w_state_nxt = REQ;
                end
            end
            DRAIN: begin
                if (redir_en) w_pc_nxt = w_target;
                if (imem_valid) w_state_nxt = REQ;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_pc         <= RESET_PC;
            r_hold_pc    <= '0;
            r_hold_instr <= W_NOP;
            r_if_valid   <= 1'b0;
            r_if_pc      <= '0;
            r_if_instr   <= W_NOP;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (w_hold_ld) begin
                r_hold_pc    <= r_pc;
                r_hold_instr <= imem_rdata;
            end
            if (redir_en) begin
                r_if_valid <= 1'b0;
                r_if_instr <= W_NOP;
            end else if (w_emit_mem) begin
                r_if_valid <= 1'b1;
                r_if_pc    <= r_pc;
                r_if_instr <= imem_rdata;
            end else if (w_emit_hold) begin
                r_if_valid <= 1'b1;
                r_if_pc    <= r_hold_pc;
                r_if_instr <= r_hold_instr;
            end else if (!stall) begin
                r_if_valid <= 1'b0;
                r_if_instr <= W_NOP;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: latency-programmable imem model plus a PC
// scoreboard consumed whenever decode takes an instruction.
module tb_fetch_stage;

    localparam logic [31:0] NOP_W = 32'hD503201F;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        redir_en = 1'b0;
    logic        redir_uncond = 1'b0;
    logic [63:0] redir_pc = '0;
    logic [18:0] CondAddr19 = '0;
    logic [25:0] BrAddr26 = '0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [63:0] if_pc;
    logic [31:0] if_instr;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] sb_q[$];

    logic        mem_busy = 1'b0;
    int          mem_cnt  = 0;
    logic [63:0] mem_addr = '0;
    int          mem_lat  = 0;
    logic        mem_off  = 1'b0;

    fetch_stage dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .redir_en     (redir_en),
        .redir_uncond (redir_uncond),
        .redir_pc     (redir_pc),
        .CondAddr19   (CondAddr19),
        .BrAddr26     (BrAddr26),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_valid   (imem_valid),
        .imem_rdata   (imem_rdata),
        .if_valid     (if_valid),
        .if_pc        (if_pc),
        .if_instr     (if_instr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_data(input logic [63:0] a);
        return 32'hAAAA0001 + a[33:2];
    endfunction

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory: response mem_lat cycles after the request is first seen.
    assign imem_valid = !mem_off &&
                        ((mem_lat == 0 && imem_req) ||
                         (mem_busy && mem_cnt == mem_lat));
    assign imem_rdata = mem_data(mem_busy ? mem_addr : imem_addr);

    always @(posedge clk) begin
        if (mem_busy) begin
            if (mem_cnt == mem_lat) begin
                if (!mem_off) mem_busy <= 1'b0;
            end else begin
                mem_cnt <= mem_cnt + 1;
            end
        end else if (imem_req && mem_lat != 0) begin
            mem_busy <= 1'b1;
            mem_cnt  <= 1;
            mem_addr <= imem_addr;
        end
    end

    always @(negedge clk) begin
        if (reset && if_valid && !stall) begin
            if (sb_q.size() == 0) begin
                chk("sb_extra", 64'(if_valid), 64'd0);
            end else begin
                logic [63:0] e;
                e = sb_q.pop_front();
                chk("sb_pc", if_pc, e);
                chk("sb_instr", 64'(if_instr), 64'(mem_data(e)));
            end
        end
        if (mem_busy && imem_req)
            chk("addr_stable", imem_addr, mem_addr);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset then zero-latency streaming
        tick();
        tick();
        chk("rst_valid", 64'(if_valid), 64'd0);
        chk("rst_pc", if_pc, 64'd0);
        chk("rst_instr", 64'(if_instr), 64'(NOP_W));
        chk("rst_req", 64'(imem_req), 64'd0);
        sb_q.push_back(64'h0);
        sb_q.push_back(64'h4);
        sb_q.push_back(64'h8);
        reset = 1'b1;
        tick();
        chk("t1_req", 64'(imem_req), 64'd1);
        chk("t1_addr0", imem_addr, 64'h0);
        tick();
        chk("t1_addr4", imem_addr, 64'h4);
        chk("t1_v0", 64'(if_valid), 64'd1);
        chk("t1_pc0", if_pc, 64'h0);
        tick();
        chk("t1_addr8", imem_addr, 64'h8);
        chk("t1_pc4", if_pc, 64'h4);
        tick();
        chk("t1_pc8", if_pc, 64'h8);
        chk("t1_ins8", 64'(if_instr), 64'(mem_data(64'h8)));
        mem_off = 1'b1;
        tick();
        chk("t1_bubble", 64'(if_valid), 64'd0);
        chk("t1_sb", 64'(sb_q.size()), 64'd0);

        // 2: latency 2, one instruction per three cycles
        sb_q.push_back(64'hC);
        sb_q.push_back(64'h10);
        mem_lat = 2;
        mem_off = 1'b0;
        tick();
        chk("t2_req", 64'(imem_req), 64'd1);
        chk("t2_addr_a", imem_addr, 64'hC);
        chk("t2_nvld", 64'(imem_valid), 64'd0);
        tick();
        chk("t2_addr_b", imem_addr, 64'hC);
        chk("t2_vld", 64'(imem_valid), 64'd1);
        tick();
        chk("t2_pc12", if_pc, 64'hC);
        chk("t2_v12", 64'(if_valid), 64'd1);
        chk("t2_addr16", imem_addr, 64'h10);
        tick();
        chk("t2_gap", 64'(if_valid), 64'd0);
        tick();
        tick();
        chk("t2_pc16", if_pc, 64'h10);
        chk("t2_v16", 64'(if_valid), 64'd1);

        // 3: stall three cycles while a response arrives
        sb_q.push_back(64'h14);
        stall = 1'b1;
        tick();
        chk("t3_frz_pc_a", if_pc, 64'h10);
        chk("t3_frz_v_a", 64'(if_valid), 64'd1);
        tick();
        chk("t3_rsp", 64'(imem_valid), 64'd1);
        chk("t3_frz_pc_b", if_pc, 64'h10);
        tick();
        chk("t3_frz_pc_c", if_pc, 64'h10);
        chk("t3_frz_ins", 64'(if_instr), 64'(mem_data(64'h10)));
        chk("t3_hold_req", 64'(imem_req), 64'd0);
        stall = 1'b0;
        tick();
        chk("t3_held_pc", if_pc, 64'h14);
        chk("t3_held_ins", 64'(if_instr), 64'(mem_data(64'h14)));
        chk("t3_next_addr", imem_addr, 64'h18);
        tick();
        chk("t3_bubble", 64'(if_valid), 64'd0);

        // 4: unconditional redirect while a request is in flight
        redir_en     = 1'b1;
        redir_uncond = 1'b1;
        redir_pc     = 64'h100;
        BrAddr26     = 26'h3FFFFFE;
        tick();
        redir_en = 1'b0;
        chk("t4_flush_v", 64'(if_valid), 64'd0);
        chk("t4_flush_ins", 64'(if_instr), 64'(NOP_W));
        chk("t4_drain_req", 64'(imem_req), 64'd0);
        chk("t4_target", imem_addr, 64'hF8);
        chk("t4_stale", 64'(imem_valid), 64'd1);
        sb_q.push_back(64'hF8);
        tick();
        chk("t4_drop", 64'(if_valid), 64'd0);
        chk("t4_req", 64'(imem_req), 64'd1);
        chk("t4_addr", imem_addr, 64'hF8);
        tick();
        tick();
        tick();
        chk("t4_pcF8", if_pc, 64'hF8);

        // 5: conditional redirect wrapping below zero, then pc wraps up
        mem_lat      = 0;
        redir_en     = 1'b1;
        redir_uncond = 1'b0;
        redir_pc     = 64'h0;
        CondAddr19   = 19'h7FFFF;
        sb_q.push_back(64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        redir_en = 1'b0;
        chk("t5_target", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("t5_flush", 64'(if_valid), 64'd0);
        tick();
        chk("t5_wrap", imem_addr, 64'h0);
        chk("t5_pc", if_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        chk("t5_pc0", if_pc, 64'h0);

        // 6a: redirect beats stall while in HOLD
        stall = 1'b1;
        tick();
        chk("t6_frz", if_pc, 64'h0);
        chk("t6_hold_req", 64'(imem_req), 64'd0);
        redir_en     = 1'b1;
        redir_uncond = 1'b1;
        redir_pc     = 64'h200;
        BrAddr26     = 26'h4;
        sb_q.push_back(64'h210);
        tick();
        redir_en = 1'b0;
        stall    = 1'b0;
        chk("t6_flush_v", 64'(if_valid), 64'd0);
        chk("t6_flush_ins", 64'(if_instr), 64'(NOP_W));
        chk("t6_addr", imem_addr, 64'h210);
        tick();
        chk("t6_nohold", if_pc, 64'h210);

        // 6b: reset during an in-flight request
        mem_lat = 2;
        tick();
        chk("t6_inflight", imem_addr, 64'h214);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("t6_rst_req", 64'(imem_req), 64'd0);
        chk("t6_late", 64'(imem_valid), 64'd1);
        chk("t6_rst_v", 64'(if_valid), 64'd0);
        chk("t6_rst_pc", imem_addr, 64'h0);
        sb_q.push_back(64'h0);
        tick();
        chk("t6_ign_v", 64'(if_valid), 64'd0);
        chk("t6_req", 64'(imem_req), 64'd1);
        tick();
        tick();
        tick();
        chk("t6_pc0", if_pc, 64'h0);
        chk("t6_v0", 64'(if_valid), 64'd1);
        mem_off = 1'b1;
        tick();
        tick();
        chk("sb_left", 64'(sb_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
